// File: rtl/irq_ctl.sv
// Eight-source interrupt controller for a 65C02 bus: synchronises sources,
// latches edges, masks with ENABLE and drives a registered IRQ plus a register window.
module irq_ctl #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic [7:0]  DI,
  input  logic        WE,
  input  logic        RDY,
  input  logic [7:0]  src,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        IRQ
);

  typedef enum logic [2:0] {
    OFF_STATUS  = 3'd0,
    OFF_ENABLE  = 3'd1,
    OFF_PENDING = 3'd2,
    OFF_EDGE    = 3'd3,
    OFF_VECTOR  = 3'd4,
    OFF_SWSET   = 3'd5,
    OFF_RSVD6   = 3'd6,
    OFF_RSVD7   = 3'd7
  } reg_off_e;

  logic [7:0] sync1_q, s_q, p_q;
  logic [7:0] enable_q, edge_q, latch_q;
  logic [7:0] rise, pend, act, vector, rd_val, latch_d;
  logic       hit, wr;
  reg_off_e   off;

  assign hit  = (AB[15:3] == BASE[15:3]);
  assign off  = reg_off_e'(AB[2:0]);
  assign wr   = hit & WE & RDY;
  assign rise = s_q & ~p_q;
  assign pend = (edge_q & latch_q) | (~edge_q & s_q);
  assign act  = pend & enable_q;

  // Lowest-numbered active source wins; 8'h80 flags "nothing active".
  always_comb begin
    vector = 8'h80;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) vector = {5'b0, 3'(i)};
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_val = 8'h00;
    case (off)
      OFF_STATUS:  rd_val = act;
      OFF_ENABLE:  rd_val = enable_q;
      OFF_PENDING: rd_val = pend;
      OFF_EDGE:    rd_val = edge_q;
      OFF_VECTOR:  rd_val = vector;
      default:     rd_val = 8'h00;
    endcase
  end

  // Hardware sets are applied after the PENDING clear so a coincident set wins;
  // the old EDGE value gates sets, then a new EDGE value masks the result.
  always_comb begin
    latch_d = latch_q;
    if (wr && off == OFF_PENDING) latch_d = latch_d & ~(DI & edge_q);
    latch_d = latch_d | (edge_q & rise);
    if (wr && off == OFF_SWSET)   latch_d = latch_d | (DI & edge_q);
    if (wr && off == OFF_EDGE)    latch_d = latch_d & DI;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      sync1_q  <= '0;
      s_q      <= '0;
      p_q      <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      latch_q  <= '0;
      IRQ      <= 1'b0;
      rdata    <= '0;
      sel      <= 1'b0;
    end else begin
      sync1_q <= src;
      s_q     <= sync1_q;
      p_q     <= s_q;
      latch_q <= latch_d;
      IRQ     <= |act;
      if (wr && off == OFF_ENABLE) enable_q <= DI;
      if (wr && off == OFF_EDGE)   edge_q   <= DI;
      if (RDY) begin
        sel   <= hit & ~WE;
        rdata <= hit ? rd_val : 8'h00;
      end
    end
  end

endmodule
